hs_rr_arbiter: RTL and testbench

Round-robin arbiter that shares one registered valid/ready output stage between `NUM_REQ` requester channels.
- Each requester presents a valid/ready/data stream with a packet-end marker. The block grants one requester, locks the grant until that requester's last beat is accepted, then advances priority.
- The output is a single registered stage (one beat deep) that sits in front of a downstream handshake consumer.

---
 rtl/hs_arb_pkg.sv | 40 ++++
 rtl/hs_rr_arbiter_if.sv | 33 +++
 rtl/rr_priority_pick.sv | 32 +++
 rtl/hs_rr_arbiter.sv | 129 ++++++++++++
 tb/tb_hs_rr_arbiter.sv | 352 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/hs_arb_pkg.sv
// Shared arbitration types and helpers.
//   arb_state_e : grant-lock state (IDLE / LOCK)
//   rr_pick_t   : result of a circular priority search (found flag + index)
//   rr_pick()   : first set bit of valid_vec at or after ptr, wrapping at num_req
package hs_arb_pkg;

  localparam int unsigned MAX_REQ    = 32;
  localparam int unsigned PICK_IDX_W = $clog2(MAX_REQ);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_LOCK = 1'b1
  } arb_state_e;

  typedef struct packed {
    logic                  found;
    logic [PICK_IDX_W-1:0] idx;
  } rr_pick_t;

  // Circular search; only the first num_req bits of valid_vec take part.
  function automatic rr_pick_t rr_pick(input logic [MAX_REQ-1:0] valid_vec,
                                       input int unsigned        num_req,
                                       input int unsigned        ptr);
    rr_pick_t    res;
    int unsigned cand;
    res = '0;
    for (int unsigned i = 0; i < MAX_REQ; i++) begin
      cand = ptr + i;
      if (cand >= num_req) begin
        cand = cand - num_req;
      end
      if ((i < num_req) && !res.found && valid_vec[cand[PICK_IDX_W-1:0]]) begin
        res.found = 1'b1;
        res.idx   = cand[PICK_IDX_W-1:0];
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/hs_rr_arbiter_if.sv
// Requester-side and output-side handshake bundle of hs_rr_arbiter.
//   req_valid_i/req_last_i/req_data_i/req_ready_o : per-requester streams
//   valid_o/data_o/last_o/src_o/ready_i            : registered output stage
//   busy_o                                         : packet lock held
// slave modport is the arbiter's view; master is the environment's view.
interface hs_rr_arbiter_if #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned DATA_W  = 8
);
  localparam int unsigned SRC_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]        req_valid_i;
  logic [NUM_REQ-1:0]        req_last_i;
  logic [NUM_REQ*DATA_W-1:0] req_data_i;
  logic [NUM_REQ-1:0]        req_ready_o;
  logic                      valid_o;
  logic [DATA_W-1:0]         data_o;
  logic                      last_o;
  logic [SRC_W-1:0]          src_o;
  logic                      ready_i;
  logic                      busy_o;

  modport slave (
    input  req_valid_i, req_last_i, req_data_i, ready_i,
    output req_ready_o, valid_o, data_o, last_o, src_o, busy_o
  );

  modport master (
    output req_valid_i, req_last_i, req_data_i, ready_i,
    input  req_ready_o, valid_o, data_o, last_o, src_o, busy_o
  );

endinterface

// File: rtl/rr_priority_pick.sv
// Combinational circular priority encoder.
//   req         : request vector
//   ptr         : highest-priority index this cycle
//   grant_oh_c  : one-hot grant (zero when nothing requests)
//   grant_idx_c : binary index of the grant
//   found_c     : at least one request present
module rr_priority_pick
  import hs_arb_pkg::*;
#(
  parameter  int unsigned NUM_REQ = 4,
  localparam int unsigned SRC_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [SRC_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant_oh_c,
  output logic [SRC_W-1:0]   grant_idx_c,
  output logic               found_c
);

  rr_pick_t pick_c;

  always_comb begin
    pick_c      = rr_pick(MAX_REQ'(req), NUM_REQ, 32'(ptr));
    found_c     = pick_c.found;
    grant_idx_c = SRC_W'(pick_c.idx);
    grant_oh_c  = '0;
    if (pick_c.found) begin
      grant_oh_c[grant_idx_c] = 1'b1;
    end
  end

endmodule

// File: rtl/hs_rr_arbiter.sv
// Round-robin packet arbiter feeding one registered valid/ready stage.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : hs_rr_arbiter_if.slave (requester streams, output stage, busy)
// A grant is held from the first to the last beat of a packet; priority then
// moves to the requester after the one that finished.
module hs_rr_arbiter
  import hs_arb_pkg::*;
#(
  parameter  int unsigned NUM_REQ = 4,
  parameter  int unsigned DATA_W  = 8,
  localparam int unsigned SRC_W   = $clog2(NUM_REQ)
) (
  input  logic          clk,
  input  logic          rst,
  hs_rr_arbiter_if.slave bus
);

  arb_state_e         state_q;
  logic [SRC_W-1:0]   ptr_q;
  logic [SRC_W-1:0]   owner_q;
  logic               busy_q;
  logic               valid_q;
  logic [DATA_W-1:0]  data_q;
  logic               last_q;
  logic [SRC_W-1:0]   src_q;

  logic [NUM_REQ-1:0] pick_oh_c;
  logic [SRC_W-1:0]   pick_idx_c;
  logic               pick_found_c;

  logic               space_c;
  logic [SRC_W-1:0]   grant_c;
  logic [NUM_REQ-1:0] ready_c;
  logic               accept_c;
  logic               beat_last_c;
  logic [DATA_W-1:0]  beat_data_c;

  // Explicit wrap so non-power-of-two requester counts stay in range.
  function automatic logic [SRC_W-1:0] wrap_inc(input logic [SRC_W-1:0] idx);
    return (idx == SRC_W'(NUM_REQ - 1)) ? '0 : idx + SRC_W'(1);
  endfunction

  rr_priority_pick #(
    .NUM_REQ (NUM_REQ)
  ) u_pick (
    .req         (bus.req_valid_i),
    .ptr         (ptr_q),
    .grant_oh_c  (pick_oh_c),
    .grant_idx_c (pick_idx_c),
    .found_c     (pick_found_c)
  );

  // Grant selection and handshake; the owner keeps ready while locked even
  // with its valid low, so a stalled owner simply idles the stage.
  always_comb begin
    space_c     = !valid_q || bus.ready_i;
    grant_c     = pick_idx_c;
    ready_c     = '0;
    beat_last_c = 1'b0;
    beat_data_c = '0;
    if (state_q == ST_LOCK) begin
      grant_c = owner_q;
      if (!rst && space_c) begin
        ready_c[owner_q] = 1'b1;
      end
    end else if (!rst && space_c && pick_found_c) begin
      ready_c = pick_oh_c;
    end
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (grant_c == SRC_W'(k)) begin
        beat_last_c = bus.req_last_i[k];
        beat_data_c = bus.req_data_i[k*DATA_W +: DATA_W];
      end
    end
    accept_c = |(ready_c & bus.req_valid_i);
  end

  // Lock state, priority pointer and output stage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      owner_q <= '0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
      data_q  <= '0;
      last_q  <= 1'b0;
      src_q   <= '0;
    end else begin
      if (accept_c) begin
        valid_q <= 1'b1;
        data_q  <= beat_data_c;
        last_q  <= beat_last_c;
        src_q   <= grant_c;
      end else if (bus.ready_i) begin
        valid_q <= 1'b0;
      end

      case (state_q)
        ST_IDLE: begin
          if (accept_c) begin
            if (beat_last_c) begin
              ptr_q <= wrap_inc(grant_c);
            end else begin
              state_q <= ST_LOCK;
              owner_q <= grant_c;
              busy_q  <= 1'b1;
            end
          end
        end
        ST_LOCK: begin
          if (accept_c && beat_last_c) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
            ptr_q   <= wrap_inc(owner_q);
          end
        end
      endcase
    end
  end

  assign bus.req_ready_o = ready_c;
  assign bus.valid_o     = valid_q;
  assign bus.data_o      = data_q;
  assign bus.last_o      = last_q;
  assign bus.src_o       = src_q;
  assign bus.busy_o      = busy_q;

endmodule

// File: tb/tb_hs_rr_arbiter.sv
// Bench for hs_rr_arbiter: a 4-requester and a 3-requester instance share
// clock and reset. Bench-side requesters replay per-requester beat queues;
// a spec-level model (lock flag, owner, pointer, one-beat stage) predicts
// every output each cycle, and directed scenarios pin sequences literally.
module tb_hs_rr_arbiter;

  localparam int unsigned DW = 8;

  logic clk;
  logic rst;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  hs_rr_arbiter_if #(.NUM_REQ(4), .DATA_W(DW)) bus4 ();
  hs_rr_arbiter_if #(.NUM_REQ(3), .DATA_W(DW)) bus3 ();

  hs_rr_arbiter #(.NUM_REQ(4), .DATA_W(DW)) dut4 (.clk(clk), .rst(rst), .bus(bus4));
  hs_rr_arbiter #(.NUM_REQ(3), .DATA_W(DW)) dut3 (.clk(clk), .rst(rst), .bus(bus3));

  int         n_req [2] = '{4, 3};
  logic       rv   [2][4];
  logic       rl   [2][4];
  logic [7:0] rd   [2][4];
  logic       hold [2][4];
  logic       acc  [2][4];
  logic       rdy  [2];
  logic [8:0] rq   [8][$];
  bit         rand_mode;

  int         m_ptr   [2];
  int         m_owner [2];
  int         m_src   [2];
  bit         m_lock  [2];
  bit         m_v     [2];
  bit         m_last  [2];
  logic [7:0] m_data  [2];

  int lg_src0[$];
  int lg_dat0[$];
  int lg_cyc0[$];
  int lg_src1[$];

  int vectors;
  int miscompares;
  int cyc;

  int exp_lock_d [6] = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h33, 8'h30};

  always_comb begin
    bus4.ready_i = rdy[0];
    bus3.ready_i = rdy[1];
    for (int k = 0; k < 4; k++) begin
      bus4.req_valid_i[k]         = rv[0][k];
      bus4.req_last_i[k]          = rl[0][k];
      bus4.req_data_i[k*DW +: DW] = rd[0][k];
    end
    for (int k = 0; k < 3; k++) begin
      bus3.req_valid_i[k]         = rv[1][k];
      bus3.req_last_i[k]          = rl[1][k];
      bus3.req_data_i[k*DW +: DW] = rd[1][k];
    end
  end

  task automatic chk(input string nm, input int u, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s [inst %0d] cyc %0d: got %0d, want %0d", nm, u, cyc, act, exp);
    end
  endtask

  task automatic enqueue_pkt(input int u, input int k, input int len, input int base);
    logic [8:0] b;
    for (int i = 0; i < len; i++) begin
      b = {1'(i == len - 1), 8'(base + i)};
      rq[u*4+k].push_back(b);
    end
  endtask

  task automatic flush();
    for (int u = 0; u < 2; u++) begin
      for (int k = 0; k < 4; k++) begin
        rv[u][k]   = 1'b0;
        rl[u][k]   = 1'b0;
        rd[u][k]   = '0;
        hold[u][k] = 1'b0;
        rq[u*4+k].delete();
      end
    end
  endtask

  task automatic clear_logs();
    lg_src0.delete();
    lg_dat0.delete();
    lg_cyc0.delete();
    lg_src1.delete();
  endtask

  // Requesters: retire an accepted beat, then present the next queued one.
  task automatic feed();
    logic [8:0] b;
    for (int u = 0; u < 2; u++) begin
      for (int k = 0; k < n_req[u]; k++) begin
        if (acc[u][k]) rv[u][k] = 1'b0;
        if (!rv[u][k] && !hold[u][k] && rq[u*4+k].size() != 0 &&
            (!rand_mode || $urandom_range(3) != 0)) begin
          b = rq[u*4+k].pop_front();
          rv[u][k] = 1'b1;
          rl[u][k] = b[8];
          rd[u][k] = b[7:0];
        end
      end
    end
  endtask

  // Compare registered outputs and ready, then advance the model one edge.
  task automatic model_cycle(input int u);
    logic       av, al, ab;
    logic [7:0] ad;
    int         as;
    logic [3:0] ar, er;
    int         g;
    bit         have, space;
    if (u == 0) begin
      av = bus4.valid_o; ad = bus4.data_o; al = bus4.last_o;
      as = int'(bus4.src_o); ab = bus4.busy_o; ar = bus4.req_ready_o;
    end else begin
      av = bus3.valid_o; ad = bus3.data_o; al = bus3.last_o;
      as = int'(bus3.src_o); ab = bus3.busy_o; ar = {1'b0, bus3.req_ready_o};
    end
    if (rst) begin
      m_ptr[u] = 0; m_owner[u] = 0; m_lock[u] = 0; m_v[u] = 0;
      m_data[u] = '0; m_last[u] = 0; m_src[u] = 0;
    end
    chk("valid_o", u, int'(av), int'(m_v[u]));
    chk("data_o",  u, int'(ad), int'(m_data[u]));
    chk("last_o",  u, int'(al), int'(m_last[u]));
    chk("src_o",   u, as, m_src[u]);
    chk("busy_o",  u, int'(ab), int'(m_lock[u]));
    if (!rst && av && rdy[u]) begin
      if (u == 0) begin
        lg_src0.push_back(as); lg_dat0.push_back(int'(ad)); lg_cyc0.push_back(cyc);
      end else begin
        lg_src1.push_back(as);
      end
    end
    for (int k = 0; k < 4; k++) acc[u][k] = 1'b0;
    space = !m_v[u] || rdy[u];
    have  = 0;
    g     = 0;
    if (!rst) begin
      if (m_lock[u]) begin
        g = m_owner[u];
        have = 1;
      end else begin
        for (int i = 0; i < n_req[u]; i++) begin
          int c;
          c = (m_ptr[u] + i) % n_req[u];
          if (!have && rv[u][c]) begin
            g = c;
            have = 1;
          end
        end
      end
    end
    er = (have && space) ? 4'(1 << g) : 4'b0;
    chk("req_ready_o", u, int'(ar), int'(er));
    if (!rst) begin
      if (have && space && rv[u][g]) begin
        acc[u][g] = 1'b1;
        m_v[u]    = 1;
        m_data[u] = rd[u][g];
        m_last[u] = rl[u][g];
        m_src[u]  = g;
        if (rl[u][g]) begin
          m_lock[u] = 0;
          m_ptr[u]  = (g + 1) % n_req[u];
        end else begin
          m_lock[u]  = 1;
          m_owner[u] = g;
        end
      end else if (rdy[u]) begin
        m_v[u] = 0;
      end
    end
  endtask

  task automatic tick();
    feed();
    @(negedge clk);
    model_cycle(0);
    model_cycle(1);
    @(posedge clk);
    cyc++;
    #1;
  endtask

  function automatic bit all_idle();
    bit idle;
    idle = 1;
    for (int u = 0; u < 2; u++) begin
      if (m_v[u]) idle = 0;
      for (int k = 0; k < 4; k++) begin
        if (rv[u][k] || rq[u*4+k].size() != 0) idle = 0;
      end
    end
    return idle;
  endfunction

  task automatic run_idle(input int maxc);
    int c;
    c = 0;
    while (!all_idle() && c < maxc) begin
      tick();
      c++;
    end
    chk("drain_in_budget", 0, int'(all_idle()), 1);
  endtask

  task automatic check_src(input int u, input string nm, input string exp);
    int got;
    got = (u == 0) ? lg_src0.size() : lg_src1.size();
    chk({nm, "_count"}, u, got, exp.len());
    for (int i = 0; i < exp.len() && i < got; i++) begin
      chk(nm, u, (u == 0) ? lg_src0[i] : lg_src1[i], int'(exp[i]) - 48);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, cyc %0d", cyc);
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    rand_mode = 0;
    vectors = 0;
    miscompares = 0;
    cyc = 0;
    rdy[0] = 1'b1;
    rdy[1] = 1'b1;
    flush();
    for (int u = 0; u < 2; u++) begin
      for (int k = 0; k < 4; k++) acc[u][k] = 1'b0;
      m_ptr[u] = 0; m_owner[u] = 0; m_src[u] = 0;
      m_lock[u] = 0; m_v[u] = 0; m_last[u] = 0; m_data[u] = '0;
    end
    repeat (2) tick();
    rst = 1'b0;

    // Reset in the middle of requester 2's 3-beat packet.
    enqueue_pkt(0, 2, 3, 8'hA0);
    tick();
    chk("pre_rst_busy", 0, int'(bus4.busy_o), 1);
    chk("pre_rst_data", 0, int'(bus4.data_o), 8'hA0);
    rst = 1'b1;
    #1;
    chk("rst_valid", 0, int'(bus4.valid_o), 0);
    chk("rst_busy",  0, int'(bus4.busy_o), 0);
    chk("rst_ready", 0, int'(bus4.req_ready_o), 0);
    flush();
    repeat (2) tick();
    rst = 1'b0;
    clear_logs();
    enqueue_pkt(0, 0, 1, 8'h01);
    enqueue_pkt(0, 3, 1, 8'h03);
    run_idle(50);
    check_src(0, "post_rst_order", "03");

    // Round robin with single-beat packets; 3-requester wrap in parallel.
    clear_logs();
    for (int r = 0; r < 3; r++) begin
      for (int k = 0; k < 4; k++) enqueue_pkt(0, k, 1, 8'h20 + 4*r + k);
    end
    for (int r = 0; r < 2; r++) begin
      for (int k = 0; k < 3; k++) enqueue_pkt(1, k, 1, 8'h40 + 3*r + k);
    end
    run_idle(100);
    check_src(0, "rr_order", "012301230123");
    check_src(1, "wrap3_order", "012012");
    if (lg_cyc0.size() == 12) chk("rr_no_bubble", 0, lg_cyc0[11] - lg_cyc0[0], 11);

    // Packet lock: requester 1 holds the grant while 0 and 3 wait.
    clear_logs();
    enqueue_pkt(0, 1, 4, 8'h10);
    tick();
    enqueue_pkt(0, 0, 1, 8'h30);
    enqueue_pkt(0, 3, 1, 8'h33);
    run_idle(100);
    check_src(0, "lock_order", "111130");
    for (int i = 0; i < 6 && i < lg_dat0.size(); i++) chk("lock_data", 0, lg_dat0[i], exp_lock_d[i]);
    if (lg_cyc0.size() == 6) chk("lock_contiguous", 0, lg_cyc0[5] - lg_cyc0[0], 5);

    // Backpressure: stage holds its beat, then drain and refill in one cycle.
    clear_logs();
    rdy[0] = 1'b0;
    enqueue_pkt(0, 2, 2, 8'h50);
    tick();
    chk("bp_valid", 0, int'(bus4.valid_o), 1);
    chk("bp_data",  0, int'(bus4.data_o), 8'h50);
    repeat (4) begin
      tick();
      chk("bp_hold_data", 0, int'(bus4.data_o), 8'h50);
      chk("bp_no_ready",  0, int'(bus4.req_ready_o), 0);
    end
    rdy[0] = 1'b1;
    tick();
    chk("bp_refill_valid", 0, int'(bus4.valid_o), 1);
    chk("bp_refill_data",  0, int'(bus4.data_o), 8'h51);
    chk("bp_refill_src",   0, int'(bus4.src_o), 2);
    run_idle(50);

    // Owner stall: requester 0 pauses mid-packet, requester 1 must wait.
    clear_logs();
    enqueue_pkt(0, 0, 3, 8'h60);
    tick();
    hold[0][0] = 1'b1;
    enqueue_pkt(0, 1, 1, 8'h70);
    repeat (4) begin
      tick();
      chk("stall_busy",  0, int'(bus4.busy_o), 1);
      chk("stall_ready", 0, int'(bus4.req_ready_o), 1);
    end
    hold[0][0] = 1'b0;
    run_idle(50);
    check_src(0, "stall_order", "0001");
    chk("stall_busy_end", 0, int'(bus4.busy_o), 0);

    // Randomised traffic with random downstream ready on both instances.
    rand_mode = 1;
    for (int t = 0; t < 3000; t++) begin
      for (int u = 0; u < 2; u++) begin
        rdy[u] = ($urandom_range(3) != 0);
        for (int k = 0; k < n_req[u]; k++) begin
          if (rq[u*4+k].size() == 0 && $urandom_range(3) == 0)
            enqueue_pkt(u, k, int'($urandom_range(4, 1)), int'($urandom_range(255)));
        end
      end
      tick();
    end
    rand_mode = 0;
    rdy[0] = 1'b1;
    rdy[1] = 1'b1;
    run_idle(400);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
